// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcode/funct fields,
// ALU control codes and trap causes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR, ST_EXEC,
        ST_ALUWB, ST_BRANCH, ST_ADDIEX, ST_ADDIWB, ST_JUMP, ST_TRAP
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_ILL_OP = 2'b01,
        CAUSE_ILL_FN = 2'b10,
        CAUSE_BUS_TO = 2'b11
    } cause_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Returns {legal, alu_control}; an unknown funct yields all zeros.
    function automatic logic [3:0] decode_funct(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return {1'b1, ALU_ADD};
            FN_SUB:  return {1'b1, ALU_SUB};
            FN_AND:  return {1'b1, ALU_AND};
            FN_OR:   return {1'b1, ALU_OR};
            FN_SLT:  return {1'b1, ALU_SLT};
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles and flags a bus timeout once the wait count
// reaches TIMEOUT while the access is still not ready. TIMEOUT=0 disables it.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] r_count;
    logic          w_at_limit;

    assign w_at_limit = (r_count == LIMIT);

    // Saturating at LIMIT keeps the count from wrapping when the timeout is disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (!busy || ready) begin
            r_count <= '0;
        end else if (!w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && busy && !ready && w_at_limit;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM with memory wait timeout and sticky trap.
// States: FETCH/MEMRD/MEMWR wait on mem_ready | DECODE dispatch | MEMADR, EXEC, ADDIEX compute
//         MEMWB, ALUWB, ADDIWB write back | BRANCH, JUMP update PC | TRAP halt until reset
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter bit HAS_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t     r_state;
    cause_t     r_cause;
    logic       w_busy;
    logic       w_expired;
    logic       w_fn_ok;
    logic [2:0] w_fn_ctl;

    assign {w_fn_ok, w_fn_ctl} = decode_funct(funct);
    assign w_busy = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rstn    (rstn),
        .busy    (w_busy),
        .ready   (mem_ready),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_FETCH;
            r_cause <= CAUSE_NONE;
        end else if (w_expired) begin
            r_state <= ST_TRAP;
            r_cause <= CAUSE_BUS_TO;
        end else begin
            case (r_state)
                ST_FETCH:  if (mem_ready) r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: r_state <= ST_MEMADR;
                        OP_RTYPE:     r_state <= ST_EXEC;
                        OP_BEQ:       r_state <= ST_BRANCH;
                        OP_ADDI:      r_state <= ST_ADDIEX;
                        OP_J:         r_state <= ST_JUMP;
                        OP_BNE: begin
                            if (HAS_BNE) begin
                                r_state <= ST_BRANCH;
                            end else begin
                                r_state <= ST_TRAP;
                                r_cause <= CAUSE_ILL_OP;
                            end
                        end
                        default: begin
                            r_state <= ST_TRAP;
                            r_cause <= CAUSE_ILL_OP;
                        end
                    endcase
                end
                ST_MEMADR: r_state <= (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
                ST_MEMRD:  if (mem_ready) r_state <= ST_MEMWB;
                ST_MEMWR:  if (mem_ready) r_state <= ST_FETCH;
                ST_EXEC: begin
                    if (w_fn_ok) begin
                        r_state <= ST_ALUWB;
                    end else begin
                        r_state <= ST_TRAP;
                        r_cause <= CAUSE_ILL_FN;
                    end
                end
                ST_ADDIEX: r_state <= ST_ADDIWB;
                ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP: r_state <= ST_FETCH;
                ST_TRAP:   r_state <= ST_TRAP;
                default:   r_state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        iord        = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        retire      = 1'b0;
        trap        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                // PC and IR must not load while reset is still asserted.
                ir_write    = mem_ready & rstn;
                pc_en       = mem_ready & rstn;
            end
            ST_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            ST_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
            end
            ST_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = w_fn_ctl;
            end
            ST_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_en       = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
                retire      = 1'b1;
            end
            ST_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            ST_TRAP:  trap = 1'b1;
            default:  trap = 1'b0;
        endcase
    end

    assign trap_cause = r_cause;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Testbench for mc_ctrl_fsm: instruction table, hand-written wait/timeout
// sequences and a randomized run against an instruction-level step model.
module tb_mc_ctrl_fsm;

    localparam int TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, alu_zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, mem_write, pc_en, iord, ir_write, reg_write, reg_dst;
    logic       mem_to_reg, alu_src_a, retire, trap;
    logic [1:0] pc_src, alu_src_b, trap_cause;
    logic [2:0] alu_control;

    logic       rstn_z, alu_zero_z, mem_ready_z;
    logic [5:0] opcode_z, funct_z;
    logic       z_mem_req, z_mem_write, z_pc_en, z_iord, z_ir_write, z_reg_write, z_reg_dst;
    logic       z_mem_to_reg, z_alu_src_a, z_retire, z_trap;
    logic [1:0] z_pc_src, z_alu_src_b, z_trap_cause;
    logic [2:0] z_alu_control;

    mc_ctrl_fsm #(.TIMEOUT(TO), .HAS_BNE(1'b1)) u_dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .pc_en(pc_en),
        .pc_src(pc_src), .iord(iord), .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .retire(retire), .trap(trap),
        .trap_cause(trap_cause)
    );

    mc_ctrl_fsm #(.TIMEOUT(0), .HAS_BNE(1'b0)) u_dut_z (
        .clk(clk), .rstn(rstn_z), .opcode(opcode_z), .funct(funct_z), .alu_zero(alu_zero_z),
        .mem_ready(mem_ready_z), .mem_req(z_mem_req), .mem_write(z_mem_write), .pc_en(z_pc_en),
        .pc_src(z_pc_src), .iord(z_iord), .ir_write(z_ir_write), .reg_write(z_reg_write),
        .reg_dst(z_reg_dst), .mem_to_reg(z_mem_to_reg), .alu_src_a(z_alu_src_a),
        .alu_src_b(z_alu_src_b), .alu_control(z_alu_control), .retire(z_retire), .trap(z_trap),
        .trap_cause(z_trap_cause)
    );

    typedef struct packed {
        logic       mem_req, mem_write, pc_en;
        logic [1:0] pc_src;
        logic       iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       retire, trap;
        logic [1:0] trap_cause;
    } outs_t;

    outs_t act;
    assign act = {mem_req, mem_write, pc_en, pc_src, iord, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_control, retire, trap, trap_cause};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Step-level reference: each instruction is a list of steps; memory steps
    // stretch until ready or until the wait budget runs out.
    typedef enum int {K_FETCH, K_DEC, K_ADR, K_RD, K_MWB, K_WR, K_EXEC, K_AWB,
                      K_BR, K_AEX, K_AWB2, K_JMP, K_TRAP} kind_e;

    kind_e      mq[$];
    logic [1:0] mcause;
    int         mwait;
    int         trap_hold;

    function automatic logic fn_legal(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic outs_t expect_out(input kind_e k, input logic rdy, input logic z,
                                         input logic [5:0] op, input logic [5:0] fn,
                                         input logic [1:0] cause);
        outs_t e;
        e = '0;
        case (k)
            K_FETCH: begin e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_control = 3'b010;
                           e.ir_write = rdy; e.pc_en = rdy; end
            K_DEC:   begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; end
            K_ADR, K_AEX: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
            K_RD:    begin e.mem_req = 1; e.iord = 1; end
            K_MWB:   begin e.reg_write = 1; e.mem_to_reg = 1; e.retire = 1; end
            K_WR:    begin e.mem_req = 1; e.mem_write = 1; e.iord = 1; e.retire = rdy; end
            K_EXEC:  begin e.alu_src_a = 1; e.alu_control = alu_of(fn); end
            K_AWB:   begin e.reg_write = 1; e.reg_dst = 1; e.retire = 1; end
            K_BR:    begin e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_src = 2'b01;
                           e.pc_en = (op == 6'b000101) ? !z : z; e.retire = 1; end
            K_AWB2:  begin e.reg_write = 1; e.retire = 1; end
            K_JMP:   begin e.pc_src = 2'b10; e.pc_en = 1; e.retire = 1; end
            default: begin e.trap = 1; e.trap_cause = cause; end
        endcase
        return e;
    endfunction

    task automatic plan(input logic [5:0] op, input logic [5:0] fn);
        mq.delete();
        mwait  = 0;
        mcause = 2'b00;
        mq.push_back(K_FETCH);
        mq.push_back(K_DEC);
        case (op)
            6'b100011: begin mq.push_back(K_ADR); mq.push_back(K_RD); mq.push_back(K_MWB); end
            6'b101011: begin mq.push_back(K_ADR); mq.push_back(K_WR); end
            6'b000000: begin
                mq.push_back(K_EXEC);
                if (fn_legal(fn)) mq.push_back(K_AWB);
                else begin mq.push_back(K_TRAP); mcause = 2'b10; end
            end
            6'b000100, 6'b000101: mq.push_back(K_BR);
            6'b001000: begin mq.push_back(K_AEX); mq.push_back(K_AWB2); end
            6'b000010: mq.push_back(K_JMP);
            default:   begin mq.push_back(K_TRAP); mcause = 2'b01; end
        endcase
    endtask

    task automatic model_step(input logic rdy);
        kind_e k;
        k = mq[0];
        if (k == K_TRAP) return;
        if (k inside {K_FETCH, K_RD, K_WR}) begin
            if (rdy) begin
                void'(mq.pop_front());
                mwait = 0;
            end else if (mwait == TO) begin
                mq.delete();
                mq.push_back(K_TRAP);
                mcause = 2'b11;
                mwait  = 0;
            end else begin
                mwait++;
            end
        end else begin
            void'(mq.pop_front());
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_outs", 32'(act), 32'(expect_out(K_FETCH, 1'b0, 1'b0, 6'd0, 6'd0, 2'b00)));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mq.delete();
        mwait = 0;
        trap_hold = 0;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cyc;
        logic       pc_en;
        logic       rw;
        logic [2:0] alu3;
        logic [1:0] cause;
        int         ret;
    } vec_t;

    vec_t vt[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         got_cyc, ret_cnt, wr, stall_left;
        logic       pe, rw_any, tr, rt, seen;
        logic [2:0] a3;
        logic [1:0] cs;
        logic [5:0] ops[8];
        logic [5:0] fns[5];
        outs_t      e;
        kind_e      k;

        vt[0]  = '{6'b100011, 6'b100000, 1'b0, 5, 1'b0, 1'b1, 3'b010, 2'b00, 1};
        vt[1]  = '{6'b101011, 6'b100000, 1'b0, 4, 1'b0, 1'b0, 3'b010, 2'b00, 1};
        vt[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 1'b0, 1'b1, 3'b010, 2'b00, 1};
        vt[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 1'b0, 1'b1, 3'b110, 2'b00, 1};
        vt[4]  = '{6'b000000, 6'b100100, 1'b0, 4, 1'b0, 1'b1, 3'b000, 2'b00, 1};
        vt[5]  = '{6'b000000, 6'b100101, 1'b0, 4, 1'b0, 1'b1, 3'b001, 2'b00, 1};
        vt[6]  = '{6'b000000, 6'b101010, 1'b0, 4, 1'b0, 1'b1, 3'b111, 2'b00, 1};
        vt[7]  = '{6'b000100, 6'b000000, 1'b1, 3, 1'b1, 1'b0, 3'b110, 2'b00, 1};
        vt[8]  = '{6'b000100, 6'b000000, 1'b0, 3, 1'b0, 1'b0, 3'b110, 2'b00, 1};
        vt[9]  = '{6'b000101, 6'b000000, 1'b0, 3, 1'b1, 1'b0, 3'b110, 2'b00, 1};
        vt[10] = '{6'b000101, 6'b000000, 1'b1, 3, 1'b0, 1'b0, 3'b110, 2'b00, 1};
        vt[11] = '{6'b001000, 6'b000000, 1'b0, 4, 1'b0, 1'b1, 3'b010, 2'b00, 1};
        vt[12] = '{6'b000010, 6'b000000, 1'b0, 3, 1'b1, 1'b0, 3'b000, 2'b00, 1};
        vt[13] = '{6'b111111, 6'b000000, 1'b0, 3, 1'b0, 1'b0, 3'b000, 2'b01, 0};
        vt[14] = '{6'b000000, 6'b000111, 1'b0, 4, 1'b0, 1'b0, 3'b000, 2'b10, 0};

        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        rstn = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        rstn_z = 1'b0; opcode_z = '0; funct_z = '0; alu_zero_z = 1'b0; mem_ready_z = 1'b0;
        mcause = 2'b00; mwait = 0; trap_hold = 0; stall_left = 0;

        for (int r = 0; r < 15; r++) begin
            do_reset();
            opcode = vt[r].op; funct = vt[r].fn; alu_zero = vt[r].z; mem_ready = 1'b1;
            got_cyc = 0; pe = 1'b0; rw_any = 1'b0; a3 = 3'b000; cs = 2'b00; ret_cnt = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clk);
                if (i == 3) a3 = alu_control;
                rw_any |= reg_write;
                ret_cnt += int'(retire);
                if (retire || trap) begin
                    got_cyc = i; pe = pc_en; cs = trap_cause;
                    break;
                end
                @(posedge clk);
                #1;
            end
            check($sformatf("vec%0d_cycles", r), 32'(got_cyc), 32'(vt[r].cyc));
            check($sformatf("vec%0d_pc_en", r), 32'(pe), 32'(vt[r].pc_en));
            check($sformatf("vec%0d_reg_write", r), 32'(rw_any), 32'(vt[r].rw));
            check($sformatf("vec%0d_alu_c3", r), 32'(a3), 32'(vt[r].alu3));
            check($sformatf("vec%0d_cause", r), 32'(cs), 32'(vt[r].cause));
            check($sformatf("vec%0d_retires", r), 32'(ret_cnt), 32'(vt[r].ret));
            if (vt[r].cause != 2'b00) begin
                do_reset();
                @(negedge clk);
                check($sformatf("vec%0d_post_reset", r), 32'({mem_req, trap, trap_cause}), 32'(4'b1000));
                @(posedge clk);
                #1;
            end
        end

        // FETCH stalls of 3 and TIMEOUT cycles; ready on the last cycle must still win.
        for (int nw = 3; nw <= TO; nw++) begin
            do_reset();
            opcode = 6'b000010;
            for (int i = 1; i <= nw + 1; i++) begin
                mem_ready = (i == nw + 1);
                @(negedge clk);
                check($sformatf("fetch_wait%0d_c%0d", nw, i), 32'({ir_write, pc_en, trap}),
                      (i == nw + 1) ? 32'd6 : 32'd0);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            check($sformatf("fetch_wait%0d_decode", nw), 32'({alu_src_b, trap}), 32'(3'b110));
            @(posedge clk);
            #1;
        end

        // sw that never completes: MEMWR holds for TIMEOUT+1 cycles, then bus trap.
        do_reset();
        opcode = 6'b101011; funct = '0; mem_ready = 1'b1; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_write) begin seen = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        check("sw_to_reach_memwr", 32'(seen), 32'd1);
        mem_ready = 1'b0;
        #1;
        wr = 0; tr = 1'b0; rt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (trap) begin tr = 1'b1; break; end
            wr += int'(mem_write);
            rt |= retire;
            @(posedge clk);
            #1;
        end
        check("sw_to_trap", 32'(tr), 32'd1);
        check("sw_to_wait_cycles", 32'(wr), 32'(TO + 1));
        check("sw_to_cause", 32'(trap_cause), 32'd3);
        check("sw_to_no_retire", 32'(rt), 32'd0);
        check("sw_to_trap_outs", 32'({mem_req, mem_write, retire}), 32'd0);

        // Randomized run against the step model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (mq.size() > 0 && mq[0] == K_TRAP && trap_hold >= 2) begin
                do_reset();
            end else if ($urandom_range(249) == 0) begin
                do_reset();
            end
            if (mq.size() == 0) begin
                opcode = ops[$urandom_range(7)];
                if (opcode == 6'b111111) opcode = 6'($urandom_range(63));
                funct = ($urandom_range(9) == 0) ? 6'($urandom_range(63)) : fns[$urandom_range(4)];
                plan(opcode, funct);
                if ($urandom_range(7) == 0) stall_left = $urandom_range(8, 2);
            end
            if (stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = ($urandom_range(99) < 60);
            end
            alu_zero = 1'($urandom_range(1));
            @(negedge clk);
            k = mq[0];
            e = expect_out(k, mem_ready, alu_zero, opcode, funct, mcause);
            check($sformatf("rand_c%0d_step%0d", c, int'(k)), 32'(act), 32'(e));
            if (k == K_TRAP) trap_hold++;
            model_step(mem_ready);
            @(posedge clk);
            #1;
        end

        // TIMEOUT=0 / HAS_BNE=0 instance: sw waits forever, bne is illegal.
        rstn_z = 1'b0; mem_ready_z = 1'b1; opcode_z = 6'b101011;
        @(posedge clk);
        #1;
        rstn_z = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (z_mem_write) begin seen = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        check("t0_reach_memwr", 32'(seen), 32'd1);
        mem_ready_z = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t0_still_waiting", 32'({z_trap, z_mem_write, z_mem_req}), 32'(3'b011));

        rstn_z = 1'b0;
        @(posedge clk);
        #1;
        rstn_z = 1'b1; opcode_z = 6'b000101; mem_ready_z = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 3) check("nobne_trap", 32'({z_trap, z_trap_cause, z_pc_en}), 32'(4'b1010));
            else begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameter TIMEOUT, default 16: max wait cycles per memory access before a bus trap; 0 disables the timeout.
REQ-002 Parameter HAS_BNE, default 1: 1 decodes bne (000101); 0 treats it as an illegal opcode.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 opcode  in  6  instruction[31:26] from the instruction register; funct  in  6  instruction[5:0].
REQ-006 alu_zero  in  1  ALU zero flag, same cycle.
REQ-007 mem_ready  in  1  memory completes the current access this cycle; read data valid this cycle.
REQ-008 mem_req  out  1  memory access active; mem_write  out  1  access is a write.
REQ-009 pc_en  out  1  PC register enable; pc_src  out  2  00 alu_result, 01 alu_out, 10 jump target.
REQ-010 iord, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath selects/enables, same meaning as in the existing datapath.
REQ-011 alu_src_b  out  2  00 rd2, 01 constant 1, 10/11 sign_imm; alu_control  out  3  add 010, sub 110, and 000, or 001, slt 111.
REQ-012 retire  out  1  one-cycle pulse on the final cycle of each completed instruction.
REQ-013 trap  out  1  sticky halt; trap_cause  out  2  00 none, 01 illegal opcode, 10 illegal funct, 11 bus timeout.

Function
REQ-014 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP; all outputs are decoded from state, mem_ready and alu_zero; unlisted outputs are 0.
REQ-015 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, add; ir_write=pc_en=mem_ready; advance to DECODE only when mem_ready=1, otherwise hold.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, add (branch target into alu_out); next state by opcode: 100011/101011 MEMADR, 000000 EXEC, 000100/000101 BRANCH, 001000 ADDIEX, 000010 JUMP, else TRAP (cause 01).
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, add; next state MEMRD for lw, MEMWR for sw.
REQ-018 MEMRD: mem_req=1, iord=1; advance to MEMWB on mem_ready. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1; next state FETCH.
REQ-019 MEMWR: mem_req=1, mem_write=1, iord=1 for every cycle of the state; retire=mem_ready; advance to FETCH on mem_ready.
REQ-020 EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); any other funct goes to TRAP (cause 10) with reg_write never asserted.
REQ-021 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1; next state FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01; pc_en=alu_zero for beq and ~alu_zero for bne; retire=1; next state FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, add; next state ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1; next state FETCH.
REQ-024 JUMP: pc_src=10, pc_en=1, retire=1; next state FETCH.
REQ-025 Wait counter: increments on each cycle with mem_req=1 and mem_ready=0; clears on mem_ready or on leaving the memory state.
REQ-026 When the counter reaches TIMEOUT with mem_ready still 0, the FSM goes to TRAP (cause 11) on the next edge, and mem_write never completes.
REQ-027 mem_ready in the same cycle the counter reaches TIMEOUT takes priority; the access completes normally.
REQ-028 TRAP: all outputs 0 except trap=1; trap_cause holds; exit only through reset.
REQ-029 mem_ready is ignored outside FETCH/MEMRD/MEMWR.

Reset
REQ-030 rstn low forces state FETCH, counter 0, trap=0, trap_cause=00 immediately, including mid-access or in TRAP.
REQ-031 During reset all outputs are 0 except the FETCH-state combinational values; pc_en and ir_write are forced to 0 while rstn=0.

Structure
REQ-032 A shared package mc_ctrl_pkg SHALL hold the state enum, opcode/funct constants, alu_control codes and trap_cause codes.
REQ-033 One sub-module, mem_wait_timer (parameter TIMEOUT; inputs busy and ready; output expired), SHALL implement REQ-025 to REQ-027.

Verification
REQ-034 lw (100011), mem_ready=1 in every memory cycle -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB (5 cycles); one retire pulse in MEMWB.
REQ-035 FETCH with mem_ready held 0 for 3 cycles, then 1 -> ir_write/pc_en high only on the 4th cycle; no trap.
REQ-036 bne with alu_zero=0 -> pc_en=1 in BRANCH; beq with alu_zero=0 -> pc_en=0 in BRANCH.
REQ-037 R-type funct 000111 -> TRAP with trap_cause=10, reg_write never asserted; rstn pulse -> FETCH, trap=0.
REQ-038 TIMEOUT=4, sw with mem_ready never asserted -> TRAP with cause 11 after 4 wait cycles; TIMEOUT=0 -> FSM waits indefinitely.
